// File: rtl/hex_counter_display.sv
`timescale 1ns/1ps
// N-digit up/down hex/BCD counter with prescaler and active-low seven-segment drive.
// Latency: count and wrap update on the edge ending a tick/load cycle; hex follows count one cycle later.
// Backpressure: none; en=0 freezes prescaler and counter, and load always wins over a tick.
module hex_counter_display #(
    parameter int NUM_DIGITS = 2,
    parameter int DIV        = 50_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      up,
    input  logic                      bcd_mode,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   load_val,
    input  logic                      blank_lz,
    output logic [4*NUM_DIGITS-1:0]   count,
    output logic                      tick,
    output logic                      wrap,
    output logic [7*NUM_DIGITS-1:0]   hex
);

    localparam int CW = 4 * NUM_DIGITS;
    localparam int HW = 7 * NUM_DIGITS;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    logic [PW-1:0] p;
    logic [CW-1:0] step_val;
    logic          step_wrap;
    logic          carry;
    logic [3:0]    digit;
    logic [CW-1:0] load_clamped;
    logic [HW-1:0] hex_nxt;
    logic          higher_zero;

    // Active-low gfedcba pattern for one nibble.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // The step is taken only in the last enabled cycle of each prescaler period.
    assign tick = en && (p == P_MAX);

    // Next count value for a step; BCD uses a per-digit ripple carry/borrow.
    always_comb begin
        step_val  = count;
        step_wrap = 1'b0;
        carry     = 1'b1;
        digit     = 4'd0;
        if (!bcd_mode) begin
            if (up) begin
                {step_wrap, step_val} = {1'b0, count} + (CW+1)'(1);
            end else begin
                step_val  = count - CW'(1);
                step_wrap = (count == '0);
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit = count[4*i +: 4];
                if (carry) begin
                    if (up) begin
                        if (digit >= 4'd9) begin
                            step_val[4*i +: 4] = 4'd0;
                        end else begin
                            step_val[4*i +: 4] = digit + 4'd1;
                            carry = 1'b0;
                        end
                    end else begin
                        if (digit == 4'd0) begin
                            step_val[4*i +: 4] = 4'd9;
                        end else if (digit > 4'd9) begin
                            // Leftover hex digit snaps to 9 without borrowing.
                            step_val[4*i +: 4] = 4'd9;
                            carry = 1'b0;
                        end else begin
                            step_val[4*i +: 4] = digit - 4'd1;
                            carry = 1'b0;
                        end
                    end
                end
            end
            step_wrap = carry;
        end
    end

    // Load value, with non-decimal nibbles clamped to 9 in BCD mode.
    always_comb begin
        load_clamped = load_val;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_mode && (load_val[4*i +: 4] > 4'd9)) begin
                load_clamped[4*i +: 4] = 4'd9;
            end
        end
    end

    // Segment image of the current count; scan from the top digit to find leading zeros.
    always_comb begin
        hex_nxt     = '0;
        higher_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            higher_zero = higher_zero && (count[4*i +: 4] == 4'd0);
            if (blank_lz && (i > 0) && higher_zero) begin
                hex_nxt[7*i +: 7] = SEG_BLANK;
            end else begin
                hex_nxt[7*i +: 7] = seg7(count[4*i +: 4]);
            end
        end
    end

    // Prescaler: restarts on load, holds while disabled, wraps after DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
        end else if (load) begin
            p <= '0;
        end else if (en) begin
            p <= (p == P_MAX) ? '0 : p + PW'(1);
        end
    end

    // Counter and wrap pulse; load has priority over a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            wrap  <= 1'b0;
        end else if (tick) begin
            count <= step_val;
            wrap  <= step_wrap;
        end else begin
            wrap  <= 1'b0;
        end
    end

    // Registered segment outputs; reset shows unblanked zeros on every digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex <= {NUM_DIGITS{SEG_ZERO}};
        end else begin
            hex <= hex_nxt;
        end
    end

endmodule

// File: tb/tb_hex_counter_display.sv
`timescale 1ns/1ps
// Bench for hex_counter_display: a two-digit DIV=4 instance against a cycle model,
// plus a one-digit DIV=2 instance for the asynchronous mid-run reset case.
// Inputs change just after a rising edge; outputs are sampled before the next edge.
module tb_hex_counter_display;

    localparam int ND  = 2;
    localparam int DV  = 4;
    localparam int CW  = 4 * ND;
    localparam int HW  = 7 * ND;
    localparam int MOD = 1 << CW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, en, up, bcd_mode, load, blank_lz;
    logic [CW-1:0] load_val;
    logic [CW-1:0] count;
    logic          tick, wrap;
    logic [HW-1:0] hex;

    logic       r1_rst_n, r1_en, r1_up, r1_bcd_mode, r1_load, r1_blank_lz;
    logic [3:0] r1_load_val;
    logic [3:0] r1_count;
    logic       r1_tick, r1_wrap;
    logic [6:0] r1_hex;

    hex_counter_display #(.NUM_DIGITS(ND), .DIV(DV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .bcd_mode(bcd_mode),
        .load(load), .load_val(load_val), .blank_lz(blank_lz),
        .count(count), .tick(tick), .wrap(wrap), .hex(hex)
    );

    hex_counter_display #(.NUM_DIGITS(1), .DIV(2)) dut1 (
        .clk(clk), .rst_n(r1_rst_n), .en(r1_en), .up(r1_up), .bcd_mode(r1_bcd_mode),
        .load(r1_load), .load_val(r1_load_val), .blank_lz(r1_blank_lz),
        .count(r1_count), .tick(r1_tick), .wrap(r1_wrap), .hex(r1_hex)
    );

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int n_pass = 0;
    int n_total = 0;

    // Reference state: counter value, prescaler phase, wrap pulse, expected segment image.
    int            m_cnt;
    int            m_p;
    bit            m_wrap;
    logic [HW-1:0] m_hex;
    int            cyc_no;
    int            tick_seen;
    int            tick_first;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [HW-1:0] exp_hex(input int v, input bit blank);
        logic [HW-1:0] r;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            if (blank && i > 0 && (v >> (4 * i)) == 0)
                r[7*i +: 7] = 7'h7F;
            else
                r[7*i +: 7] = seg_tab[(v >> (4 * i)) & 15];
        end
        return r;
    endfunction

    function automatic int clampv(input int v, input bit bcd);
        int r;
        int d;
        r = 0;
        for (int i = 0; i < ND; i++) begin
            d = (v >> (4 * i)) & 15;
            if (bcd && d > 9) d = 9;
            r = r | (d << (4 * i));
        end
        return r;
    endfunction

    // Hex: integer arithmetic modulo 16^N. BCD: locate the lowest digit that absorbs
    // the step; every digit below it rolls over.
    task automatic step_model(input int v, input bit dir_up, input bit bcd,
                              output int nv, output bit nw);
        int d [ND];
        int k;
        nv = 0;
        nw = 0;
        if (!bcd) begin
            if (dir_up) begin
                nw = (v == MOD - 1);
                nv = (v + 1) % MOD;
            end else begin
                nw = (v == 0);
                nv = (v + MOD - 1) % MOD;
            end
        end else begin
            k = -1;
            for (int i = 0; i < ND; i++) d[i] = (v >> (4 * i)) & 15;
            for (int i = 0; i < ND; i++) begin
                if (k < 0 && (dir_up ? (d[i] < 9) : (d[i] != 0))) k = i;
            end
            if (k < 0) begin
                nw = 1;
                for (int i = 0; i < ND; i++) d[i] = dir_up ? 0 : 9;
            end else begin
                for (int i = 0; i < k; i++) d[i] = dir_up ? 0 : 9;
                if (dir_up) d[k] = d[k] + 1;
                else        d[k] = (d[k] > 9) ? 9 : d[k] - 1;
            end
            for (int i = 0; i < ND; i++) nv = nv | (d[i] << (4 * i));
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_p    = 0;
        m_wrap = 0;
        m_hex  = {ND{7'b1000000}};
    endtask

    // One clock cycle: compare all outputs with the model, then advance both across the edge.
    task automatic cycle();
        bit mt;
        int nv;
        bit nw;
        #1;
        mt = en && (m_p == DV - 1);
        check("tick", tick, mt);
        check("count", count, m_cnt);
        check("wrap", wrap, m_wrap);
        check("hex", hex, m_hex);
        if (tick === 1'b1) begin
            tick_seen++;
            if (tick_first < 0) tick_first = cyc_no;
        end
        @(posedge clk);
        m_hex = exp_hex(m_cnt, blank_lz);
        if (load) begin
            m_cnt  = clampv(load_val, bcd_mode);
            m_p    = 0;
            m_wrap = 0;
        end else begin
            if (mt) begin
                step_model(m_cnt, up, bcd_mode, nv, nw);
                m_cnt  = nv;
                m_wrap = nw;
            end else begin
                m_wrap = 0;
            end
            if (en) m_p = (m_p + 1) % DV;
        end
        #1;
        cyc_no++;
    endtask

    // Run cycles until the DUT raises tick; n counts cycles including the tick cycle.
    task automatic run_until_tick(input int budget, output int n);
        bit hit;
        hit = 0;
        n = 0;
        for (int k = 0; k < budget && !hit; k++) begin
            #1;
            if (tick === 1'b1) hit = 1;
            cycle();
            n++;
        end
        if (!hit) check("tick_timeout", 1'b0, 1'b1);
    endtask

    task automatic load_tick(input string tag, input int val, input bit dir,
                             input int exp_cnt, input bit exp_wrap);
        int n;
        up = dir;
        load = 1'b1;
        load_val = CW'(val);
        cycle();
        load = 1'b0;
        run_until_tick(10, n);
        check({tag, "_count"}, count, exp_cnt);
        check({tag, "_wrap"}, wrap, exp_wrap);
    endtask

    task automatic load_show(input int val);
        load = 1'b1;
        load_val = CW'(val);
        cycle();
        load = 1'b0;
        cycle();
    endtask

    initial begin
        int n;
        int saved;
        rst_n = 1'b0; en = 1'b1; up = 1'b1; bcd_mode = 1'b0; load = 1'b0;
        load_val = '0; blank_lz = 1'b1;
        r1_rst_n = 1'b0; r1_en = 1'b1; r1_up = 1'b1; r1_bcd_mode = 1'b0;
        r1_load = 1'b0; r1_load_val = 4'd0; r1_blank_lz = 1'b0;
        model_reset();
        tick_seen = 0; tick_first = -1; cyc_no = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with en=1 and blank_lz=1 to show they have no effect.
        check("rst_count", count, 0);
        check("rst_wrap", wrap, 0);
        check("rst_tick", tick, 0);
        check("rst_hex", hex, {ND{7'b1000000}});

        // Free-running hex count from release.
        blank_lz = 1'b0;
        rst_n = 1'b1;
        cyc_no = 1;
        repeat (64) cycle();
        check("t1_ticks", tick_seen, 16);
        check("t1_first_tick", tick_first, DV);
        check("t1_count", count, 8'h10);
        cycle();
        check("t1_hex", hex, {7'b1111001, 7'b1000000});

        // Hex wrap at all-F.
        load = 1'b1; load_val = 8'hFF;
        cycle();
        load = 1'b0;
        run_until_tick(10, n);
        check("t2_tick_dist", n, DV);
        check("t2_count", count, 8'h00);
        check("t2_wrap", wrap, 1);
        cycle();
        check("t2_wrap_clear", wrap, 0);

        // BCD carry, borrow and clamp.
        bcd_mode = 1'b1;
        load_tick("t3_up99", 8'h99, 1'b1, 8'h00, 1'b1);
        load_tick("t3_dn00", 8'h00, 1'b0, 8'h99, 1'b1);
        load_tick("t3_dn10", 8'h10, 1'b0, 8'h09, 1'b0);
        load = 1'b1; load_val = 8'hAB;
        cycle();
        load = 1'b0;
        check("t3_clamp", count, 8'h99);

        // Leading-zero blanking with the counter frozen.
        en = 1'b0; blank_lz = 1'b1;
        load_show(8'h05);
        check("t4_hex05", hex, {7'b1111111, 7'b0010010});
        load_show(8'h00);
        check("t4_hex00", hex, {7'b1111111, 7'b1000000});
        load_show(8'h50);
        check("t4_hex50", hex, {7'b0010010, 7'b1000000});

        // Load coinciding with a tick, then a freeze in the tick cycle.
        en = 1'b1; up = 1'b1; bcd_mode = 1'b0; blank_lz = 1'b0;
        for (int k = 0; k < DV && m_p != DV - 1; k++) cycle();
        load = 1'b1; load_val = 8'h3C;
        cycle();
        load = 1'b0;
        check("t5_load_in_tick", count, 8'h3C);
        run_until_tick(10, n);
        check("t5_restart_dist", n, DV);
        check("t5_step", count, 8'h3D);
        for (int k = 0; k < DV && m_p != DV - 1; k++) cycle();
        saved = m_cnt;
        en = 1'b0;
        repeat (10) cycle();
        check("t5_hold_count", count, saved);
        en = 1'b1;
        run_until_tick(3, n);
        check("t5_resume_dist", n, 1);

        // Randomised run against the model.
        for (int k = 0; k < 400; k++) begin
            en       = ($urandom_range(0, 7) != 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = CW'($urandom);
            if ($urandom_range(0, 7) == 0) up = ~up;
            if ($urandom_range(0, 31) == 0) bcd_mode = ~bcd_mode;
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            cycle();
        end
        load = 1'b0;

        // One-digit DIV=2 instance: run to 7, reset between edges, release.
        r1_rst_n = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        check("t6_count7", r1_count, 4'h7);
        #2;
        r1_rst_n = 1'b0;
        #1;
        check("t6_async_count", r1_count, 4'h0);
        check("t6_async_hex", r1_hex, 7'b1000000);
        check("t6_async_tick", r1_tick, 1'b0);
        #1;
        r1_rst_n = 1'b1;
        #1;
        check("t6_rel_cyc1", r1_tick, 1'b0);
        @(posedge clk);
        #1;
        check("t6_rel_cyc2", r1_tick, 1'b1);
        @(posedge clk);
        #1;
        check("t6_rel_count", r1_count, 4'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
